// File: rtl/if_fetch_stage_if.sv
// Instruction-memory request/acknowledge port between the fetch stage and imem.
// Read data is only meaningful in the cycle imem_ack_i is high.
interface if_fetch_stage_if;
    logic        imem_req_o;
    logic [15:0] imem_addr_o;
    logic        imem_ack_i;
    logic [15:0] imem_data_i;

    modport master (output imem_req_o, output imem_addr_o, input imem_ack_i, input imem_data_i);
    modport slave  (input imem_req_o, input imem_addr_o, output imem_ack_i, output imem_data_i);
endinterface

// File: rtl/if_fetch_stage.sv
// mcpu instruction-fetch stage: owns the PC, runs the imem req/ack port and loads
// the IF/ID register, with a one-entry skid buffer absorbing an ack that lands during a stall.
module if_fetch_stage #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [15:0] NOP_INST = 16'h0800
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stall_i,
    input  logic                   flush_i,
    input  logic                   br_taken_i,
    input  logic [15:0]            br_target_i,
    if_fetch_stage_if.master       imem,
    output logic [15:0]            id_pc_o,
    output logic [15:0]            id_inst_o,
    output logic                   id_valid_o
);
    typedef enum logic [1:0] {BOOT, FETCH, HOLD} state_e;

    state_e      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] tgt_q, tgt_d;
    logic        discard_q, discard_d;
    logic [15:0] skid_pc_q, skid_pc_d;
    logic [15:0] skid_inst_q, skid_inst_d;
    logic [15:0] id_pc_q, id_pc_d;
    logic [15:0] id_inst_q, id_inst_d;
    logic        id_valid_q, id_valid_d;
    logic        kill;

    // pc_q is the address on the bus while fetching; it stays put during a discarded
    // request so req/addr remain stable, with the redirect target parked in tgt_q.
    assign imem.imem_req_o  = (state_q == FETCH);
    assign imem.imem_addr_o = pc_q;
    assign id_pc_o          = id_pc_q;
    assign id_inst_o        = id_inst_q;
    assign id_valid_o       = id_valid_q;
    assign kill             = br_taken_i | flush_i;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        tgt_d       = tgt_q;
        discard_d   = discard_q;
        skid_pc_d   = skid_pc_q;
        skid_inst_d = skid_inst_q;
        id_pc_d     = id_pc_q;
        id_inst_d   = id_inst_q;
        id_valid_d  = id_valid_q;

        if (kill) begin
            id_valid_d = 1'b0;
            id_inst_d  = NOP_INST;
        end

        unique case (state_q)
            BOOT: begin
                state_d = FETCH;
                if (br_taken_i) pc_d = br_target_i;
            end
            FETCH: begin
                if (imem.imem_ack_i) begin
                    if (discard_q) begin
                        discard_d = 1'b0;
                        pc_d      = br_taken_i ? br_target_i : tgt_q;
                    end else if (br_taken_i) begin
                        pc_d = br_target_i;
                    end else if (flush_i) begin
                        pc_d = pc_q + 16'd1;
                    end else if (stall_i) begin
                        skid_pc_d   = pc_q;
                        skid_inst_d = imem.imem_data_i;
                        pc_d        = pc_q + 16'd1;
                        state_d     = HOLD;
                    end else begin
                        id_pc_d    = pc_q;
                        id_inst_d  = imem.imem_data_i;
                        id_valid_d = 1'b1;
                        pc_d       = pc_q + 16'd1;
                    end
                end else if (br_taken_i) begin
                    discard_d = 1'b1;
                    tgt_d     = br_target_i;
                end
            end
            HOLD: begin
                // Leaving HOLD on a kill is what empties the skid buffer.
                if (kill) begin
                    if (br_taken_i) pc_d = br_target_i;
                    state_d = FETCH;
                end else if (!stall_i) begin
                    id_pc_d    = skid_pc_q;
                    id_inst_d  = skid_inst_q;
                    id_valid_d = 1'b1;
                    state_d    = FETCH;
                end
            end
            default: state_d = BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= BOOT;
            pc_q        <= RESET_PC;
            tgt_q       <= RESET_PC;
            discard_q   <= 1'b0;
            skid_pc_q   <= 16'h0000;
            skid_inst_q <= NOP_INST;
            id_pc_q     <= 16'h0000;
            id_inst_q   <= NOP_INST;
            id_valid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            tgt_q       <= tgt_d;
            discard_q   <= discard_d;
            skid_pc_q   <= skid_pc_d;
            skid_inst_q <= skid_inst_d;
            id_pc_q     <= id_pc_d;
            id_inst_q   <= id_inst_d;
            id_valid_q  <= id_valid_d;
        end
    end
endmodule
